sum_bcd_converter: RTL and testbench
====================================

SUM_BCD_CONVERTER -- requirements
Module: sum_bcd_converter

Interface
REQ-001 Parameter IN_W, default 11: input binary width; only 11 is supported, matching the 11-bit adder sum output.
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to convert bin_in; sampled on the rising edge.
REQ-005 bin_in  input  11  unsigned binary sum (0..2047).
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  single-cycle pulse marking that the result outputs have just been updated.
REQ-008 bcd_thou  output  4  thousands digit of the last completed result.
REQ-009 bcd_hund  output  4  hundreds digit of the last completed result.
REQ-010 bcd_tens  output  4  tens digit of the last completed result.
REQ-011 bcd_ones  output  4  ones digit of the last completed result.

Function
REQ-012 The block shall perform a sequential double-dabble (shift-add-3) conversion, one bit per clock, MSB first.
REQ-013 The FSM shall have exactly two states: IDLE and SHIFT.
REQ-014 In IDLE with start=1, at the edge: latch bin_in into an 11-bit shift register, clear the 16-bit BCD scratch register, load the bit counter with 11, go to SHIFT.
REQ-015 In IDLE with start=0: remain in IDLE; the scratch register, shift register and counter hold.
REQ-016 Each SHIFT edge: first add 3 to every scratch digit that is >=5, then shift {scratch, shift register} left by one, then decrement the counter.
REQ-017 On the SHIFT edge where the counter goes 1->0, the post-shift scratch value shall be loaded into the four bcd_* outputs, done shall be set for the following cycle, and the state shall return to IDLE.
REQ-018 Latency: a start sampled at edge k shall cause done to be high in the cycle after edge k+11, i.e. exactly 11 cycles after the start edge, with results valid in that same cycle.
REQ-019 busy shall be 1 exactly when the state is SHIFT; busy and done shall never both be 1.
REQ-020 done shall be high for exactly one cycle per completed conversion.
REQ-021 start while busy=1 shall be ignored, with no queuing; bin_in changes during SHIFT shall have no effect.
REQ-022 start in the cycle where done=1 shall be accepted (back-to-back), because the state is then IDLE.
REQ-023 The bcd_* outputs shall hold the last completed result and shall not change during a conversion.
REQ-024 Every digit shall be 0..9; bcd_thou shall never exceed 2 for IN_W=11.

Reset
REQ-025 reset=1 at an edge shall force state IDLE, busy=0, done=0, all bcd_* = 0, and clear the counter, shift register and scratch register.
REQ-026 reset shall take priority over start and over an in-progress conversion; an aborted conversion shall produce no done and shall not update the outputs.
REQ-027 After reset deasserts, the block shall accept start on the very next edge.

Verification
REQ-028 reset, then start with bin_in=0 -> done 11 cycles later; digits 0,0,0,0; busy high for 11 cycles.
REQ-029 start with bin_in=2046 (max sum of two 10-bit values), then bin_in=2047 -> digits 2,0,4,6, then 2,0,4,7; also check 999 -> 0,9,9,9 and 1000 -> 1,0,0,0.
REQ-030 start bin_in=123; on cycle 5 pulse start with bin_in=456 -> single done; digits 0,1,2,3; no second conversion.
REQ-031 start bin_in=555, done; start bin_in=777 in the done cycle -> second done 11 cycles later; digits 0,7,7,7; outputs held at 0,5,5,5 in between.
REQ-032 start bin_in=1500; assert reset on cycle 6 -> busy=0, done never pulses, all digits 0; a following start with bin_in=42 -> 0,0,4,2.
REQ-033 Randomized: 500 conversions of random bin_in against a decimal reference model, checking digits, the done pulse width and the 11-cycle latency.

Source files
------------

// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble converter: turns the 11-bit adder sum into four BCD digits,
// one bit per clock, MSB first.
module sum_bcd_converter #(
  parameter int unsigned IN_W = 11
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [IN_W-1:0] i_bin_in,
  output logic            o_busy,
  output logic            o_done,
  output logic [3:0]      o_bcd_thou,
  output logic [3:0]      o_bcd_hund,
  output logic [3:0]      o_bcd_tens,
  output logic [3:0]      o_bcd_ones
);

  localparam int unsigned BCD_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CAT_W = BCD_W + IN_W;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [IN_W-1:0]  r_shift;
  logic [BCD_W-1:0] r_scratch;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_bcd;
  logic             r_busy;
  logic             r_done;

  logic [0:0]       w_state_nxt;
  logic [IN_W-1:0]  w_shift_nxt;
  logic [BCD_W-1:0] w_scratch_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [BCD_W-1:0] w_bcd_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [BCD_W-1:0] w_adj;
  logic [CAT_W-1:0] w_cat;

  // Add-3 correction on every scratch digit that would overflow a decimal digit when doubled.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < 4; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // The scratch digits and the binary shift register move left as one long word.
  assign w_cat = {w_adj, r_shift} << 1;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_scratch_nxt = r_scratch;
    w_cnt_nxt     = r_cnt;
    w_bcd_nxt     = r_bcd;
    w_done_nxt    = 1'b0;
    w_busy_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_shift_nxt   = i_bin_in;
          w_scratch_nxt = '0;
          w_cnt_nxt     = CNT_W'(IN_W);
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_scratch_nxt = w_cat[CAT_W-1:IN_W];
        w_shift_nxt   = w_cat[IN_W-1:0];
        w_cnt_nxt     = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_bcd_nxt   = w_cat[CAT_W-1:IN_W];
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_SHIFT);
  end

  // State and output registers; reset aborts any conversion without touching results beyond clearing them.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_scratch <= w_scratch_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bcd     <= w_bcd_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_bcd_thou = r_bcd[15:12];
  assign o_bcd_hund = r_bcd[11:8];
  assign o_bcd_tens = r_bcd[7:4];
  assign o_bcd_ones = r_bcd[3:0];

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Self-checking bench for sum_bcd_converter: directed table, multi-cycle corner sequences
// and randomized conversions against a decimal reference model.
module tb_sum_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] bin;
  logic        busy;
  logic        done;
  logic [3:0]  thou, hund, tens, ones;

  always #5 clk = ~clk;

  sum_bcd_converter #(.IN_W(11)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_bin_in   (bin),
    .o_busy     (busy),
    .o_done     (done),
    .o_bcd_thou (thou),
    .o_bcd_hund (hund),
    .o_bcd_tens (tens),
    .o_bcd_ones (ones)
  );

  typedef struct {
    logic [10:0] bin;
    logic [15:0] exp;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [15:0] digits();
    return {thou, hund, tens, ones};
  endfunction

  // Decimal reference: digits straight from integer division.
  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion now; return in the cycle where done is seen (or after a bounded wait).
  task automatic do_conv(input logic [10:0] b, input logic [15:0] held,
                         output int lat, output int busy_cnt, output int hold_ok, output int overlap);
    start = 1'b1;
    bin   = b;
    tick();
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    hold_ok  = 1;
    overlap  = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cnt++;
      if (digits() != held) hold_ok = 0;
      bin = 11'($urandom);
      tick();
      lat++;
    end
    if (busy && done) overlap = 1;
  endtask

  task automatic run_and_check(input string name, input logic [10:0] b,
                               input logic [15:0] held, input logic [15:0] exp);
    int lat, bc, hok, ovl;
    do_conv(b, held, lat, bc, hok, ovl);
    check({name, " latency"}, lat, 11);
    check({name, " busy_cycles"}, bc, 11);
    check({name, " hold"}, hok, 1);
    check({name, " busy_and_done"}, ovl, 0);
    check({name, " digits"}, int'(digits()), int'(exp));
  endtask

  vec_t        vecs[12];
  logic [15:0] last;
  int          done_cnt, first_lat, busy_seen;
  logic [15:0] cap;

  initial begin
    vecs[0]  = '{11'd0,    16'h0000};
    vecs[1]  = '{11'd2046, 16'h2046};
    vecs[2]  = '{11'd2047, 16'h2047};
    vecs[3]  = '{11'd999,  16'h0999};
    vecs[4]  = '{11'd1000, 16'h1000};
    vecs[5]  = '{11'd1,    16'h0001};
    vecs[6]  = '{11'd9,    16'h0009};
    vecs[7]  = '{11'd10,   16'h0010};
    vecs[8]  = '{11'd99,   16'h0099};
    vecs[9]  = '{11'd100,  16'h0100};
    vecs[10] = '{11'd1999, 16'h1999};
    vecs[11] = '{11'd2000, 16'h2000};

    // Reset takes priority over start.
    rst = 1'b1; start = 1'b1; bin = 11'd777;
    tick(); tick();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset digits", int'(digits()), 0);

    // Start on the very first edge after reset release, then the directed table.
    rst  = 1'b0;
    last = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].bin, last, vecs[i].exp);
      last = vecs[i].exp;
      tick();
      check($sformatf("vec%0d done_width", i), int'(done), 0);
    end

    // Start pulse mid-conversion is ignored.
    start = 1'b1; bin = 11'd123;
    tick();
    start = 1'b0;
    done_cnt = 0; first_lat = 0; cap = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin start = 1'b1; bin = 11'd456; end
      tick();
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin first_lat = c; cap = digits(); end
      end
    end
    check("ignore done_count", done_cnt, 1);
    check("ignore latency", first_lat, 11);
    check("ignore digits", int'(cap), 'h0123);
    check("ignore final digits", int'(digits()), 'h0123);

    // Back-to-back: restart in the done cycle.
    run_and_check("b2b first", 11'd555, 16'h0123, 16'h0555);
    run_and_check("b2b second", 11'd777, 16'h0555, 16'h0777);
    tick();
    check("b2b done_width", int'(done), 0);

    // Reset mid-conversion aborts without a done pulse.
    start = 1'b1; bin = 11'd1500;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort digits", int'(digits()), 0);
    rst = 1'b0;
    done_cnt = 0; busy_seen = 0;
    repeat (15) begin
      tick();
      if (done) done_cnt++;
      if (busy) busy_seen++;
    end
    check("abort no_done", done_cnt, 0);
    check("abort no_busy", busy_seen, 0);
    check("abort held_digits", int'(digits()), 0);
    run_and_check("after_abort", 11'd42, 16'h0000, 16'h0042);
    last = 16'h0042;
    tick();

    // Randomized conversions against the decimal model.
    for (int i = 0; i < 500; i++) begin
      logic [10:0] b;
      logic [15:0] e;
      b = 11'($urandom_range(0, 2047));
      e = ref_bcd(int'(b));
      run_and_check($sformatf("rand%0d(%0d)", i, b), b, last, e);
      last = e;
      tick();
      check($sformatf("rand%0d done_width", i), int'(done), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
